// File: rtl/mmio_port_responder.sv
// Memory-mapped responder: a 16-byte window exposing a valid/ready output port and a
// synchronized, change-detecting input port. Define PORT_IRQ_EN to enable the Irq output.
module mmio_port_responder #(
  parameter logic [31:0] PORT_BASE = 32'hEFFF_FFF0,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  output logic [31:0]          ReadData,
  output logic                 Hit,
  input  logic [IN_WIDTH-1:0]  PortIn,
  output logic [OUT_WIDTH-1:0] PortOut,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Irq
);

  typedef enum logic [1:0] {
    REG_OUT_DATA = 2'd0,
    REG_IN_DATA  = 2'd1,
    REG_STATUS   = 2'd2,
    REG_CTRL     = 2'd3
  } reg_sel_t;

  reg_sel_t             sel;
  logic                 bus_wr;
  logic                 out_wr;
  logic                 ctrl_wr;
  logic [IN_WIDTH-1:0]  sync1;
  logic [IN_WIDTH-1:0]  sync2;
  logic [IN_WIDTH-1:0]  in_prev;
  logic                 in_changed;
  logic                 irq_en;
  logic [31:0]          out_ext;
  logic [31:0]          in_ext;
  logic [31:0]          status;
  logic                 unused_bits;

  assign Hit     = (Address[31:4] == PORT_BASE[31:4]);
  assign sel     = reg_sel_t'(Address[3:2]);
  assign bus_wr  = MemWrite && Hit;
  assign out_wr  = bus_wr && (sel == REG_OUT_DATA);
  assign ctrl_wr = bus_wr && (sel == REG_CTRL);

  assign unused_bits = ^{Address[1:0], WriteData};

  // Output port: a new store always wins over a same-edge accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PortOut  <= '0;
      OutValid <= 1'b0;
    end else if (out_wr) begin
      PortOut  <= WriteData[OUT_WIDTH-1:0];
      OutValid <= 1'b1;
    end else if (OutValid && OutReady) begin
      OutValid <= 1'b0;
    end
  end

  // Input path: 2-flop synchronizer, then sticky change flag where set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      in_prev    <= '0;
      in_changed <= 1'b0;
    end else begin
      sync1   <= PortIn;
      sync2   <= sync1;
      in_prev <= sync2;
      if (sync2 != in_prev)
        in_changed <= 1'b1;
      else if (ctrl_wr && WriteData[1])
        in_changed <= 1'b0;
    end
  end

`ifdef PORT_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq_en <= 1'b0;
    else if (ctrl_wr)
      irq_en <= WriteData[2];
  end

  assign Irq = in_changed & irq_en;
`else
  assign irq_en = 1'b0;
  assign Irq    = 1'b0;
`endif

  always_comb begin
    out_ext                = '0;
    out_ext[OUT_WIDTH-1:0] = PortOut;
    in_ext                 = '0;
    in_ext[IN_WIDTH-1:0]   = sync2;
    status                 = {29'd0, irq_en, in_changed, OutValid};
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      case (sel)
        REG_OUT_DATA: ReadData = out_ext;
        REG_IN_DATA:  ReadData = in_ext;
        REG_STATUS:   ReadData = status;
        REG_CTRL:     ReadData = status;
        default:      ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: table-driven bus vectors plus hand-written
// sequences for synchronizer latency, clear/set collision, Irq and asynchronous reset.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'hEFFF_FFF0;
`ifdef PORT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        OutValid;
  logic        OutReady;
  logic        Irq;

  mmio_port_responder #(
    .PORT_BASE(BASE),
    .IN_WIDTH (8),
    .OUT_WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData),
    .Hit      (Hit),
    .PortIn   (PortIn),
    .PortOut  (PortOut),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Irq      (Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int unsigned {SIG_RD, SIG_HIT, SIG_POUT, SIG_OVAL, SIG_IRQ} sig_t;

  typedef struct {
    string       name;
    sig_t        sig;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [3:0]  off;
    logic        miss;
    logic [31:0] wdata;
    logic        ready;
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic [31:0] exp_pout;
    logic        exp_oval;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] observe(sig_t s);
    case (s)
      SIG_RD:   return ReadData;
      SIG_HIT:  return {31'd0, Hit};
      SIG_POUT: return PortOut;
      SIG_OVAL: return {31'd0, OutValid};
      default:  return {31'd0, Irq};
    endcase
  endfunction

  task automatic expect_val(input string name, input sig_t s, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.sig  = s;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t         e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = observe(e.sig);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] data);
    Address   = BASE + {28'd0, off};
    WriteData = data;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic rd_check(input string name, input logic [3:0] off, input logic [31:0] exp);
    Address  = BASE + {28'd0, off};
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    #1;
    expect_val(name, SIG_RD, exp);
    drain();
    MemRead = 1'b0;
  endtask

  task automatic irq_check(input string name, input logic exp);
    expect_val(name, SIG_IRQ, {31'd0, exp});
    drain();
  endtask

  initial begin
    vec_t v;
    reset    = 1'b1;
    PortIn   = 8'h00;
    OutReady = 1'b0;
    bus_idle();

    //            name          wr rd off   miss wdata          rdy hit rdata          pout           oval
    vecs.push_back('{"rst_out",    0, 1, 4'h0, 0, 32'h0,         0, 1, 32'h0,         32'h0,         0});
    vecs.push_back('{"rst_in",     0, 1, 4'h4, 0, 32'h0,         0, 1, 32'h0,         32'h0,         0});
    vecs.push_back('{"rst_status", 0, 1, 4'h8, 0, 32'h0,         0, 1, 32'h0,         32'h0,         0});
    vecs.push_back('{"rst_ctrl",   0, 1, 4'hC, 0, 32'h0,         0, 1, 32'h0,         32'h0,         0});
    vecs.push_back('{"miss_rd",    0, 1, 4'h0, 1, 32'h0,         0, 0, 32'h0,         32'h0,         0});
    vecs.push_back('{"st_a5",      1, 0, 4'h0, 0, 32'h0000_00A5, 0, 1, 32'h0,         32'h0000_00A5, 1});
    vecs.push_back('{"hold1",      0, 1, 4'h8, 0, 32'h0,         0, 1, 32'h1,         32'h0000_00A5, 1});
    vecs.push_back('{"hold2",      0, 1, 4'h0, 0, 32'h0,         0, 1, 32'h0000_00A5, 32'h0000_00A5, 1});
    vecs.push_back('{"hold3_ctrl", 0, 1, 4'hC, 0, 32'h0,         0, 1, 32'h1,         32'h0000_00A5, 1});
    vecs.push_back('{"byte_off",   0, 1, 4'h9, 0, 32'h0,         0, 1, 32'h1,         32'h0000_00A5, 1});
    vecs.push_back('{"accept",     0, 1, 4'h0, 0, 32'h0,         1, 1, 32'h0000_00A5, 32'h0000_00A5, 0});
    vecs.push_back('{"ready_idle", 0, 1, 4'h8, 0, 32'h0,         1, 1, 32'h0,         32'h0000_00A5, 0});
    vecs.push_back('{"st_11",      1, 0, 4'h0, 0, 32'h0000_0011, 0, 1, 32'h0,         32'h0000_0011, 1});
    vecs.push_back('{"overwrite",  1, 0, 4'h0, 0, 32'h0000_005A, 0, 1, 32'h0,         32'h0000_005A, 1});
    vecs.push_back('{"st_and_acc", 1, 0, 4'h0, 0, 32'hDEAD_BEEF, 1, 1, 32'h0,         32'hDEAD_BEEF, 1});
    vecs.push_back('{"drain_acc",  0, 1, 4'h8, 0, 32'h0,         1, 1, 32'h1,         32'hDEAD_BEEF, 0});
    vecs.push_back('{"wr_in_ign",  1, 1, 4'h4, 0, 32'h0000_00FF, 0, 1, 32'h0,         32'hDEAD_BEEF, 0});
    vecs.push_back('{"wr_st_ign",  1, 1, 4'h8, 0, 32'hFFFF_FFFF, 0, 1, 32'h0,         32'hDEAD_BEEF, 0});
    vecs.push_back('{"wr_miss",    1, 0, 4'h0, 1, 32'h0000_1234, 0, 0, 32'h0,         32'hDEAD_BEEF, 0});
    vecs.push_back('{"no_read",    0, 0, 4'h0, 0, 32'h0,         0, 1, 32'h0,         32'hDEAD_BEEF, 0});

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v         = vecs[i];
      Address   = BASE + (v.miss ? 32'd16 : 32'd0) + {28'd0, v.off};
      WriteData = v.wdata;
      MemWrite  = v.wr;
      MemRead   = v.rd;
      OutReady  = v.ready;
      #1;
      expect_val({v.name, "_hit"}, SIG_HIT, {31'd0, v.exp_hit});
      expect_val({v.name, "_rdata"}, SIG_RD, v.exp_rd);
      drain();
      tick();
      expect_val({v.name, "_pout"}, SIG_POUT, v.exp_pout);
      expect_val({v.name, "_oval"}, SIG_OVAL, {31'd0, v.exp_oval});
      drain();
    end
    bus_idle();
    OutReady = 1'b0;

    // Synchronizer latency and sticky change flag.
    PortIn = 8'h3C;
    rd_check("in_edge0", 4'h4, 32'h0);
    tick();
    rd_check("in_edge1", 4'h4, 32'h0);
    tick();
    rd_check("in_edge2", 4'h4, 32'h3C);
    rd_check("chg_edge2", 4'h8, 32'h0);
    tick();
    rd_check("chg_edge3", 4'h8, 32'h2);
    wr(4'hC, 32'h2);
    rd_check("chg_cleared", 4'h8, 32'h0);

    // Clear lands on the same edge the new change sets the flag.
    PortIn = 8'h3D;
    tick();
    tick();
    rd_check("chg_pending", 4'h8, 32'h0);
    wr(4'hC, 32'h2);
    rd_check("set_wins", 4'h8, 32'h2);
    rd_check("in_3d", 4'h4, 32'h3D);
    wr(4'hC, 32'h2);
    rd_check("chg_clear2", 4'h8, 32'h0);

    // Interrupt enable and clear.
    wr(4'hC, 32'h4);
    rd_check("irq_en_rd", 4'h8, IRQ ? 32'h4 : 32'h0);
    PortIn = 8'h01;
    tick();
    tick();
    irq_check("irq_early", 1'b0);
    tick();
    irq_check("irq_set", IRQ);
    rd_check("irq_status", 4'h8, IRQ ? 32'h6 : 32'h2);
    wr(4'hC, 32'h6);
    irq_check("irq_clr", 1'b0);
    rd_check("irq_clr_status", 4'h8, IRQ ? 32'h4 : 32'h0);

    // Asynchronous reset mid-cycle while a transfer and a change flag are pending.
    wr(4'h0, 32'h0000_CAFE);
    PortIn = 8'h80;
    repeat (3) tick();
    rd_check("pre_rst_status", 4'h8, IRQ ? 32'h7 : 32'h3);
    Address = BASE + 32'h8;
    MemRead = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    expect_val("rst_oval", SIG_OVAL, 32'h0);
    expect_val("rst_pout", SIG_POUT, 32'h0);
    expect_val("rst_status_rd", SIG_RD, 32'h0);
    expect_val("rst_irq", SIG_IRQ, 32'h0);
    drain();
    rd_check("rst_in_sync", 4'h4, 32'h0);
    tick();
    reset = 1'b0;
    bus_idle();
    tick();
    tick();
    rd_check("post_rst_in", 4'h4, 32'h80);
    tick();
    rd_check("post_rst_chg", 4'h8, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
